// File: rtl/axis_frame_checker_if.sv
// AXI-Stream link carrying the 64-bit acquisition frame stream.
interface axis_frame_checker_if;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that parses MAGIC/timestamp/payload frames and keeps framing, payload and
// timestamp-continuity statistics for the status register bank.
module axis_frame_checker #(
  parameter int unsigned DATA_WORDS     = 35,
  parameter logic [63:0] MAGIC          = 64'hDEADBEEFCAFEBABE,
  parameter logic [63:0] EXPECT_PAYLOAD = 64'h123456789ABCDEF0,
  parameter bit          CHECK_PAYLOAD  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  axis_frame_checker_if.slave  s_axis,
  input  logic                 enable,
  input  logic                 clear_stats,
  output logic [31:0]          frames_ok,
  output logic [31:0]          frames_err,
  output logic [63:0]          last_timestamp,
  output logic [15:0]          ts_gap_count,
  output logic [15:0]          discard_count,
  output logic [3:0]           err_flags,
  output logic                 in_frame,
  output logic                 frame_done,
  output logic                 frame_good
);

  localparam int unsigned     CntW     = $clog2(DATA_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(DATA_WORDS - 1);

  typedef enum logic [1:0] {StHunt, StTs, StPayload} state_e;

  state_e          state_q, state_d;
  logic            tready_q;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [63:0]     ts_shadow_q, ts_shadow_d;
  logic            mismatch_q, mismatch_d;

  logic [31:0] ok_q, err_q;
  logic [63:0] last_ts_q;
  logic        ts_valid_q;
  logic [15:0] gap_q, disc_q;
  logic [3:0]  flags_q;
  logic        done_q, good_q;

  logic       beat, beat_bad, frame_mm, ts_gap;
  logic       ev_done, ev_good, ev_err, ev_disc;
  logic [3:0] ev_flags;

  assign beat     = s_axis.tvalid & tready_q;
  assign beat_bad = CHECK_PAYLOAD && (s_axis.tdata != EXPECT_PAYLOAD);
  assign frame_mm = mismatch_q | beat_bad;
  assign ts_gap   = ts_valid_q && (ts_shadow_q != last_ts_q + 64'd1);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    ts_shadow_d = ts_shadow_q;
    mismatch_d  = mismatch_q;
    ev_done     = 1'b0;
    ev_good     = 1'b0;
    ev_err      = 1'b0;
    ev_disc     = 1'b0;
    ev_flags    = 4'b0000;
    if (beat) begin
      unique case (state_q)
        StHunt: begin
          if (s_axis.tdata == MAGIC) begin
            if (s_axis.tlast) begin
              ev_flags[1] = 1'b1;
              ev_err      = 1'b1;
              ev_done     = 1'b1;
            end else begin
              state_d = StTs;
            end
          end else begin
            // tlast on a hunted beat carries no meaning
            ev_flags[0] = 1'b1;
            ev_disc     = 1'b1;
          end
        end
        StTs: begin
          ts_shadow_d = s_axis.tdata;
          word_cnt_d  = '0;
          mismatch_d  = 1'b0;
          if (s_axis.tlast) begin
            ev_flags[1] = 1'b1;
            ev_err      = 1'b1;
            ev_done     = 1'b1;
            state_d     = StHunt;
          end else begin
            state_d = StPayload;
          end
        end
        StPayload: begin
          ev_flags[3] = beat_bad;
          if (word_cnt_q == LastWord) begin
            ev_done = 1'b1;
            state_d = StHunt;
            if (!s_axis.tlast) begin
              ev_flags[2] = 1'b1;
              ev_err      = 1'b1;
            end else if (frame_mm) begin
              ev_err = 1'b1;
            end else begin
              ev_good = 1'b1;
            end
          end else if (s_axis.tlast) begin
            ev_flags[1] = 1'b1;
            ev_err      = 1'b1;
            ev_done     = 1'b1;
            state_d     = StHunt;
          end else begin
            word_cnt_d = word_cnt_q + CntW'(1);
            mismatch_d = frame_mm;
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StHunt;
      tready_q    <= 1'b0;
      word_cnt_q  <= '0;
      ts_shadow_q <= '0;
      mismatch_q  <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tready_q    <= enable;
      word_cnt_q  <= word_cnt_d;
      ts_shadow_q <= ts_shadow_d;
      mismatch_q  <= mismatch_d;
      done_q      <= ev_done;
      good_q      <= ev_good;
    end
  end

  // Statistics; a coincident clear_stats overrides any update from the same beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ok_q       <= '0;
      err_q      <= '0;
      last_ts_q  <= '0;
      ts_valid_q <= 1'b0;
      gap_q      <= '0;
      disc_q     <= '0;
      flags_q    <= '0;
    end else if (clear_stats) begin
      ok_q       <= '0;
      err_q      <= '0;
      last_ts_q  <= '0;
      ts_valid_q <= 1'b0;
      gap_q      <= '0;
      disc_q     <= '0;
      flags_q    <= '0;
    end else begin
      if (ev_good) begin
        ok_q       <= ok_q + 32'd1;
        last_ts_q  <= ts_shadow_q;
        ts_valid_q <= 1'b1;
        if (ts_gap && (gap_q != 16'hFFFF)) begin
          gap_q <= gap_q + 16'd1;
        end
      end
      if (ev_err) begin
        err_q <= err_q + 32'd1;
      end
      if (ev_disc && (disc_q != 16'hFFFF)) begin
        disc_q <= disc_q + 16'd1;
      end
      flags_q <= flags_q | ev_flags;
    end
  end

  assign s_axis.tready  = tready_q;
  assign frames_ok      = ok_q;
  assign frames_err     = err_q;
  assign last_timestamp = last_ts_q;
  assign ts_gap_count   = gap_q;
  assign discard_count  = disc_q;
  assign err_flags      = flags_q;
  assign in_frame       = (state_q != StHunt);
  assign frame_done     = done_q;
  assign frame_good     = good_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Randomised frame-level stimulus for axis_frame_checker, scored against a per-frame outcome model.
module tb_axis_frame_checker;

  localparam int unsigned DW    = 35;
  localparam logic [63:0] MAGIC = 64'hDEADBEEFCAFEBABE;
  localparam logic [63:0] EXP   = 64'h123456789ABCDEF0;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic clear_stats = 1'b0;

  always #5 clk = ~clk;

  axis_frame_checker_if bif ();
  axis_frame_checker_if bif2 ();

  assign bif2.tdata  = bif.tdata;
  assign bif2.tvalid = bif.tvalid;
  assign bif2.tlast  = bif.tlast;

  logic [31:0] frames_ok, frames_err, ok2, err2;
  logic [63:0] last_timestamp, last_ts2;
  logic [15:0] ts_gap_count, discard_count, gap2, disc2;
  logic [3:0]  err_flags, flags2;
  logic        in_frame, frame_done, frame_good, in_frame2, done2, good2;

  axis_frame_checker #(.DATA_WORDS(DW)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .s_axis         (bif),
    .enable         (enable),
    .clear_stats    (clear_stats),
    .frames_ok      (frames_ok),
    .frames_err     (frames_err),
    .last_timestamp (last_timestamp),
    .ts_gap_count   (ts_gap_count),
    .discard_count  (discard_count),
    .err_flags      (err_flags),
    .in_frame       (in_frame),
    .frame_done     (frame_done),
    .frame_good     (frame_good)
  );

  axis_frame_checker #(.DATA_WORDS(DW), .CHECK_PAYLOAD(1'b0)) dut_nochk (
    .clk            (clk),
    .rstn           (rstn),
    .s_axis         (bif2),
    .enable         (enable),
    .clear_stats    (clear_stats),
    .frames_ok      (ok2),
    .frames_err     (err2),
    .last_timestamp (last_ts2),
    .ts_gap_count   (gap2),
    .discard_count  (disc2),
    .err_flags      (flags2),
    .in_frame       (in_frame2),
    .frame_done     (done2),
    .frame_good     (good2)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Expected state, updated per whole frame/segment
  logic [31:0] m_ok, m_err, m_ok2, m_err2;
  logic [15:0] m_gap, m_disc;
  logic [3:0]  m_flags;
  logic [63:0] m_last_ts;
  bit          m_ts_valid;
  int          m_done = 0, m_good = 0;
  int          seen_done = 0, seen_good = 0;
  logic [63:0] cur_ts;

  always @(posedge clk) begin
    if (frame_done) seen_done <= seen_done + 1;
    if (frame_good) seen_good <= seen_good + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_ok = '0; m_err = '0; m_ok2 = '0; m_err2 = '0;
    m_gap = '0; m_disc = '0; m_flags = '0;
    m_last_ts = '0; m_ts_valid = 1'b0;
  endtask

  task automatic model_frame_end(input bit good, input bit good_nochk, input logic [63:0] ts,
                                 input bit clr);
    m_done++;
    if (good) m_good++;
    if (clr) begin
      model_clear();
    end else begin
      if (good) begin
        m_ok++;
        if (m_ts_valid && ts != m_last_ts + 64'd1) m_gap++;
        m_last_ts  = ts;
        m_ts_valid = 1'b1;
      end else begin
        m_err++;
      end
      if (good_nochk) m_ok2++; else m_err2++;
    end
  endtask

  // Drive one beat from a negedge; returns at the negedge after it was consumed.
  task automatic send_beat(input logic [63:0] d, input logic l, input bit clr);
    int guard = 0;
    if ($urandom_range(0, 9) == 0) begin
      bif.tvalid = 1'b0;
      bif.tdata  = {$urandom, $urandom};
      bif.tlast  = 1'($urandom);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    if ($urandom_range(0, 14) == 0) begin
      enable     = 1'b0;
      bif.tvalid = 1'b0;
      repeat (2) @(negedge clk);
      bif.tvalid = 1'b1;
      bif.tdata  = d;
      bif.tlast  = l;
      repeat ($urandom_range(1, 10)) begin
        check_eq("stall_tready", bif.tready, 0);
        @(negedge clk);
      end
      enable = 1'b1;
    end
    bif.tvalid = 1'b1;
    bif.tdata  = d;
    bif.tlast  = l;
    while (bif.tready !== 1'b1 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 50) check_eq("ready_timeout", bif.tready, 1);
    clear_stats = clr;
    @(negedge clk);
    clear_stats = 1'b0;
  endtask

  task automatic seg_good(input logic [63:0] ts, input int bad_idx, input logic [63:0] bad_val,
                          input bit clr);
    bit mm;
    mm = (bad_idx >= 0) && (bad_val != EXP);
    send_beat(MAGIC, 1'b0, 1'b0);
    check_eq("in_frame_after_magic", in_frame, 1);
    send_beat(ts, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) begin
      send_beat((i == bad_idx) ? bad_val : EXP, i == DW - 1, clr && (i == DW - 1));
    end
    if (mm) m_flags[3] = 1'b1;
    model_frame_end(!mm, 1'b1, ts, clr);
  endtask

  // k = -2: tlast on MAGIC; k = -1: tlast on timestamp; k >= 0: tlast on payload word k
  task automatic seg_early(input int k);
    send_beat(MAGIC, k == -2, 1'b0);
    if (k >= -1) send_beat({$urandom, $urandom}, k == -1, 1'b0);
    for (int i = 0; i <= k; i++) send_beat(EXP, i == k, 1'b0);
    m_flags[1] = 1'b1;
    model_frame_end(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic seg_missing();
    send_beat(MAGIC, 1'b0, 1'b0);
    send_beat({$urandom, $urandom}, 1'b0, 1'b0);
    for (int i = 0; i < DW; i++) send_beat(EXP, 1'b0, 1'b0);
    m_flags[2] = 1'b1;
    model_frame_end(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic seg_junk(input logic [63:0] d, input logic l);
    send_beat(d, l, 1'b0);
    m_flags[0] = 1'b1;
    if (m_disc != 16'hFFFF) m_disc++;
  endtask

  task automatic check_all(input string tag);
    bif.tvalid = 1'b0;
    @(negedge clk);
    check_eq({tag, ".frames_ok"}, frames_ok, m_ok);
    check_eq({tag, ".frames_err"}, frames_err, m_err);
    check_eq({tag, ".ts_gap"}, ts_gap_count, m_gap);
    check_eq({tag, ".discard"}, discard_count, m_disc);
    check_eq({tag, ".err_flags"}, err_flags, m_flags);
    check_eq({tag, ".last_ts"}, last_timestamp, m_last_ts);
    check_eq({tag, ".in_frame"}, in_frame, 0);
    check_eq({tag, ".done_pulses"}, seen_done, m_done);
    check_eq({tag, ".good_pulses"}, seen_good, m_good);
    check_eq({tag, ".nochk_ok"}, ok2, m_ok2);
    check_eq({tag, ".nochk_err"}, err2, m_err2);
  endtask

  initial begin
    logic [63:0] junk;
    int          r;
    model_clear();
    bif.tvalid = 1'b0;
    bif.tdata  = '0;
    bif.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.tready", bif.tready, 0);
    check_eq("rst.frames_ok", frames_ok, 0);
    check_eq("rst.err_flags", err_flags, 0);
    check_eq("rst.in_frame", in_frame, 0);
    check_eq("rst.frame_done", frame_done, 0);
    rstn   = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    seg_good(64'd5, -1, '0, 1'b0);
    check_all("nominal");
    seg_good(64'd6, -1, '0, 1'b0);
    seg_good(64'd8, -1, '0, 1'b0);
    check_all("continuity");
    seg_early(10);
    seg_good(64'd9, -1, '0, 1'b0);
    check_all("early_tlast");
    seg_missing();
    seg_junk(64'd0, 1'b0);
    seg_good(64'd10, -1, '0, 1'b0);
    check_all("missing_tlast");
    seg_good(64'd11, 20, 64'd0, 1'b0);
    check_all("payload_mm");
    seg_good(64'd12, -1, '0, 1'b1);
    check_all("clear_on_last");
    seg_early(-2);
    seg_early(-1);
    seg_early(DW - 2);
    check_all("early_edges");

    cur_ts = 64'd100;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 4) begin
        if ($urandom_range(0, 3) == 0) cur_ts = {$urandom, $urandom};
        else cur_ts = cur_ts + 64'd1;
        if ($urandom_range(0, 4) == 0) begin
          junk = {$urandom, $urandom};
          if (junk == EXP) junk = ~junk;
          seg_good(cur_ts, $urandom_range(0, DW - 1), junk, 1'b0);
        end else begin
          seg_good(cur_ts, -1, '0, $urandom_range(0, 9) == 0);
        end
      end else if (r == 5) begin
        seg_early(int'($urandom_range(0, DW)) - 2);
      end else if (r == 6) begin
        seg_missing();
      end else if (r <= 8) begin
        junk = {$urandom, $urandom};
        if (junk == MAGIC) junk = ~junk;
        seg_junk(junk, 1'($urandom));
      end else begin
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        model_clear();
      end
      check_all("random");
    end

    // Reset in the middle of a frame
    send_beat(MAGIC, 1'b0, 1'b0);
    send_beat(64'd500, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_beat(EXP, 1'b0, 1'b0);
    rstn = 1'b0;
    #1;
    check_eq("midrst.tready", bif.tready, 0);
    check_eq("midrst.in_frame", in_frame, 0);
    check_eq("midrst.frames_ok", frames_ok, 0);
    check_eq("midrst.frames_err", frames_err, 0);
    check_eq("midrst.discard", discard_count, 0);
    check_eq("midrst.err_flags", err_flags, 0);
    check_eq("midrst.last_ts", last_timestamp, 0);
    bif.tvalid = 1'b0;
    model_clear();
    @(negedge clk);
    rstn = 1'b1;
    seg_good(64'd77, -1, '0, 1'b0);
    check_all("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/axis_frame_checker.md
# axis_frame_checker

AXI-Stream sink that receives and validates the 64-bit framed stream produced by the acquisition data generator (magic word, timestamp, fixed-length payload, TLAST on the final payload word). It sits on the same 84 MHz fabric clock as the generator and serves as an in-fabric loopback/verification endpoint. It parses frames, checks framing, payload and timestamp continuity, and exposes counters and sticky error flags for the status register bank.

## Interface
Parameters:
- DATA_WORDS, 35: payload beats per frame (≥2).
- MAGIC, 64'hDEADBEEFCAFEBABE: frame start word.
- EXPECT_PAYLOAD, 64'h123456789ABCDEF0: expected value of every payload beat.
- CHECK_PAYLOAD, 1: 1 = compare payload beats against EXPECT_PAYLOAD; 0 = skip compare.

Ports:
- clk  in  1  fabric clock; all logic on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- s_axis_tdata  in  64  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready (registered).
- s_axis_tlast  in  1  stream last.
- enable  in  1  accept data when high.
- clear_stats  in  1  single-cycle pulse: zero counters, flags, timestamp history.
- frames_ok  out  32  good frames received (wraps).
- frames_err  out  32  malformed frames (wraps).
- last_timestamp  out  64  timestamp of most recent good frame.
- ts_gap_count  out  16  good frames whose timestamp ≠ previous good +1 (saturates 0xFFFF).
- discard_count  out  16  beats discarded while hunting for MAGIC (saturates 0xFFFF).
- err_flags  out  4  sticky: [0] bad_magic, [1] early_tlast, [2] missing_tlast, [3] payload_mismatch.
- in_frame  out  1  high when FSM is not in HUNT.
- frame_done  out  1  one-cycle pulse after any frame completes (good or bad).
- frame_good  out  1  one-cycle pulse, coincident with frame_done, for good frames only.

## Operation
- Beat = s_axis_tvalid & s_axis_tready. FSM advances only on beats; otherwise holds.
- s_axis_tready <= enable each cycle (one-cycle lag). Deasserting enable mid-frame stalls; frame resumes intact when re-enabled.
- HUNT: beat with tdata==MAGIC and !tlast → TS. MAGIC with tlast → early_tlast, frames_err+1, frame_done, stay HUNT. Non-MAGIC beat → bad_magic, discard_count+1, stay HUNT (tlast ignored).
- TS: beat → ts_shadow <= tdata, word_cnt <= 0, mismatch <= 0. tlast → early_tlast, frames_err+1, frame_done, HUNT; else → PAYLOAD.
- PAYLOAD: each beat: if CHECK_PAYLOAD and tdata≠EXPECT_PAYLOAD, set per-frame mismatch and payload_mismatch flag; word_cnt+1.
  - word_cnt<DATA_WORDS-1 with tlast → early_tlast, frames_err+1, frame_done, HUNT.
  - word_cnt==DATA_WORDS-1 with tlast → complete: mismatch (including this beat) → frames_err+1; else frames_ok+1, frame_good. frame_done either way. HUNT.
  - word_cnt==DATA_WORDS-1 without tlast → missing_tlast, frames_err+1, frame_done, HUNT; following beats re-hunt for MAGIC.
- Good frame timestamp: if ts_valid and ts_shadow≠last_timestamp+1 (64-bit wrap) → ts_gap_count+1. Then last_timestamp <= ts_shadow, ts_valid <= 1. Bad frames never update last_timestamp or ts_valid.
- clear_stats: zeroes frames_ok, frames_err, ts_gap_count, discard_count, err_flags, last_timestamp, ts_valid; FSM state, word_cnt, ts_shadow, mismatch untouched. Coincident with a completing/discarded beat, clear wins (no increment, no flag set); frame_done/frame_good pulses still issue.
- err_flags bits are sticky until clear_stats or reset.

## Timing
- Reset (async assert, sync release by clk): s_axis_tready=0, all counters 0, last_timestamp=0, err_flags=0, in_frame=0, frame_done=0, frame_good=0, FSM=HUNT, ts_valid=0.
- s_axis_tready reflects enable sampled on previous edge; first accept ≥1 cycle after enable rises.
- Counters, flags, last_timestamp update at the edge consuming the completing beat; visible next cycle together with frame_done/frame_good.
- Minimum frame = DATA_WORDS+2 beats; full throughput (one beat/cycle) back-to-back, MAGIC may follow final beat on the next cycle.
- Reset asserted mid-frame: immediate return to reset values; partial frame not counted.

## Test plan
- Nominal: enable=1, frame MAGIC, ts=5, 35×EXPECT_PAYLOAD, tlast on 35th → frames_ok=1, last_timestamp=5, frame_done+frame_good one cycle after last beat, err_flags=0.
- Continuity: good frames ts=5,6,8 back-to-back → frames_ok=3, ts_gap_count=1, last_timestamp=8.
- Early tlast on payload word 10, then good frame ts=9 → frames_err=1, err_flags=4'b0010, frames_ok=1, last_timestamp=9.
- Missing tlast on word 35, then 0x0 beat, then good frame → missing_tlast and bad_magic set, frames_err=1, discard_count=1, frames_ok=1.
- Payload word 20 = 0 → frames_err=1, payload_mismatch set, frames_ok=0; repeat with CHECK_PAYLOAD=0 → frames_ok=1.
- enable low 10 cycles mid-payload with tvalid held → tready low from next cycle, frame completes good; clear_stats on completing beat → all counters 0, frame_done still pulses; rstn low mid-frame → all outputs reset values, in_frame=0.
